nmu_lookup_arbiter: RTL

- Shares the single NMU address-map lookup unit between the AXI write-address (AW) and read-address (AR) channels using round-robin arbitration.
- Sequences each lookup: pulses lookup_en, collects one or two map results (two when the burst crosses an interleave boundary), and requests the second half with next_req.
- Presents each sub-request to the NoC packetizer over a valid/ready handshake.
- Sits between the AXI slave front-end and the packetizer in the NoC master unit.

---
 rtl/nmu_lookup_arbiter_if.sv | 34 +++
 rtl/nmu_lookup_arbiter.sv | 70 +++++++
 2 files changed

// File: rtl/nmu_lookup_arbiter_if.sv
// nmu_lookup_arbiter_if: AXI address channels, map unit and packetizer signals of the lookup arbiter
interface nmu_lookup_arbiter_if #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int ID_WIDTH = 4
);
   logic aw_valid, aw_ready, ar_valid, ar_ready;
   logic [AXI_ADDR_WIDTH-1:0] aw_addr, ar_addr;
   logic [7:0] aw_len, ar_len;
   logic [ID_WIDTH-1:0] aw_id, ar_id;
   logic map_lookup_en, map_next_req, map_dest_en, map_lookup_done;
   logic [AXI_ADDR_WIDTH-1:0] map_addr, map_dest_addr;
   logic [7:0] map_len, map_dest_len;
   logic [ID_WIDTH-1:0] map_dest_id;
   logic sub_valid, sub_ready, sub_is_write, sub_last;
   logic [AXI_ADDR_WIDTH-1:0] sub_addr;
   logic [7:0] sub_len;
   logic [ID_WIDTH-1:0] sub_dest_id, sub_axi_id;
   logic busy, err_timeout;
   logic [15:0] split_cnt;
   modport slave (
      input aw_valid, aw_addr, aw_len, aw_id, ar_valid, ar_addr, ar_len, ar_id,
      input map_dest_en, map_dest_addr, map_dest_len, map_dest_id, map_lookup_done, sub_ready,
      output aw_ready, ar_ready, map_lookup_en, map_next_req, map_addr, map_len,
      output sub_valid, sub_addr, sub_len, sub_dest_id, sub_axi_id, sub_is_write, sub_last,
      output busy, err_timeout, split_cnt
   );
   modport master (
      output aw_valid, aw_addr, aw_len, aw_id, ar_valid, ar_addr, ar_len, ar_id,
      output map_dest_en, map_dest_addr, map_dest_len, map_dest_id, map_lookup_done, sub_ready,
      input aw_ready, ar_ready, map_lookup_en, map_next_req, map_addr, map_len,
      input sub_valid, sub_addr, sub_len, sub_dest_id, sub_axi_id, sub_is_write, sub_last,
      input busy, err_timeout, split_cnt
   );
endinterface

// File: rtl/nmu_lookup_arbiter.sv
// nmu_lookup_arbiter: round-robin AW/AR sharing of the NMU map lookup, splitting bursts into sub-requests
module nmu_lookup_arbiter #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int ID_WIDTH = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input logic axi_clk,
   input logic axi_rst_n,
   nmu_lookup_arbiter_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_MAP, OUT, SPLIT} state_t;
   state_t state, state_nxt;
   logic last_ar, gnt_aw, gnt_ar, expire;
   logic [7:0] wd;
   always_comb begin
      gnt_aw = bus.aw_valid & (~bus.ar_valid | last_ar);
      gnt_ar = bus.ar_valid & ~gnt_aw;
      expire = wd == 8'(TIMEOUT_CYC - 1);
      bus.aw_ready = state == IDLE && gnt_aw;
      bus.ar_ready = state == IDLE && gnt_ar;
      bus.map_lookup_en = state == LOOKUP;
      bus.map_next_req = state == SPLIT;
      bus.sub_valid = state == OUT;
      bus.busy = state != IDLE;
      // a result arriving on the expiry cycle still counts, so no error then
      bus.err_timeout = state == WAIT_MAP && expire && !bus.map_dest_en;
      state_nxt = state;
      case (state)
         IDLE: state_nxt = (gnt_aw | gnt_ar) ? LOOKUP : IDLE;
         LOOKUP, SPLIT: state_nxt = WAIT_MAP;
         WAIT_MAP: state_nxt = bus.map_dest_en ? OUT : expire ? IDLE : WAIT_MAP;
         OUT: state_nxt = !bus.sub_ready ? OUT : bus.sub_last ? IDLE : SPLIT;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge axi_clk or negedge axi_rst_n)
      if (!axi_rst_n) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge axi_clk or negedge axi_rst_n)
      if (!axi_rst_n) begin
         last_ar <= 1'b1;
         wd <= '0;
         bus.map_addr <= '0;
         bus.map_len <= '0;
         bus.sub_axi_id <= '0;
         bus.sub_is_write <= 1'b0;
         bus.sub_addr <= '0;
         bus.sub_len <= '0;
         bus.sub_dest_id <= '0;
         bus.sub_last <= 1'b0;
         bus.split_cnt <= '0;
      end else begin
         if (state == IDLE && (gnt_aw | gnt_ar)) begin
            bus.map_addr <= gnt_aw ? bus.aw_addr : bus.ar_addr;
            bus.map_len <= gnt_aw ? bus.aw_len : bus.ar_len;
            bus.sub_axi_id <= gnt_aw ? bus.aw_id : bus.ar_id;
            bus.sub_is_write <= gnt_aw;
            last_ar <= gnt_ar;
         end
         wd <= state == WAIT_MAP ? wd + 8'd1 : '0;
         if (state == WAIT_MAP && bus.map_dest_en) begin
            bus.sub_addr <= bus.map_dest_addr;
            bus.sub_len <= bus.map_dest_len;
            bus.sub_dest_id <= bus.map_dest_id;
            bus.sub_last <= bus.map_lookup_done;
         end
         if (state == OUT && bus.sub_ready && !bus.sub_last && bus.split_cnt != 16'hFFFF)
            bus.split_cnt <= bus.split_cnt + 16'd1;
      end
endmodule
